acc_cpu_param: RTL and testbench
================================

Name: acc_cpu_param

Overview:
Parametrised multi-cycle accumulator CPU with internal unified memory. It is the next generation of the team's 8-bit/16-word five-phase CPU.
- Data width and address width are generics; memory depth is 2^ADDR_W.
- Adds synchronous reset, a memory load port, carry/zero flags, JMP/HLT and an instruction-completion strobe.
- Sits at the top of the CPU subsystem; the bench drives memory through the load port.

Parameters:
DATA_W, 8, accumulator/memory word width; must satisfy DATA_W >= ADDR_W+4
ADDR_W, 4, address width; memory depth = 2^ADDR_W words
RESET_PC, 0, value loaded into pc on reset (taken modulo 2^ADDR_W)
INIT_FILE, "", if non-empty, hex file loaded into memory at time zero via $readmemh

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-high
ld_en  in  1  memory write strobe, honoured only in cycles where rst=1
ld_addr  in  ADDR_W  load address
ld_data  in  DATA_W  load data
ac  out  DATA_W  accumulator
pc  out  ADDR_W  program counter
carry  out  1  carry/no-borrow flag
zero  out  1  registered (ac==0) flag
halted  out  1  high while in HALT state
instr_done  out  1  one-cycle pulse on the edge that completes an instruction's execute phase

Behaviour:
- Instruction word is the low ADDR_W+4 bits of a memory word: bit ADDR_W+3 = I (indirect), bits ADDR_W+2..ADDR_W = opcode, low ADDR_W bits = address. Upper bits are ignored.
- Reset (rst=1 at edge): ac=0, pc=RESET_PC, carry=0, zero=1, halted=0, instr_done=0, state=T0. Memory is not cleared.
- Load port: when rst=1 and ld_en=1, M[ld_addr]<=ld_data. A reset asserted mid-instruction abandons the instruction; no memory or ac write occurs.
- State machine T0->T1->T2->T3->T4->T0, five cycles per instruction, plus a terminal HALT state:
  - T0: AR<=pc.
  - T1: IR<=M[AR]; pc<=pc+1, wrapping modulo 2^ADDR_W.
  - T2: decode; AR<=IR address field.
  - T3: HLT (opcode 111, I=1) goes to HALT. Otherwise, if I=1, AR<=M[AR][ADDR_W-1:0]. Then go to T4.
  - T4: execute; instr_done=1 for this cycle only; go to T0.
  - HALT: all state frozen; halted=1; exit only by rst.
- Opcodes (T4):
  - 000 ADD: {carry,ac}<=ac+M[AR].
  - 001 SUB: ac<=ac-M[AR]; carry<=1 if ac>=M[AR] (no borrow), else 0.
  - 010 XOR: ac<=ac^M[AR]; carry unchanged.
  - 011 DBL: M[AR]<=M[AR]+M[AR], truncated to DATA_W.
  - 100 LDA: ac<=M[AR].
  - 101 STA: M[AR]<=ac.
  - 110 CMM: M[AR]<=~M[AR].
  - 111 with I=0, JMP: pc<=AR (direct only).
- zero is updated on every ac write with the new ac value; it is unchanged otherwise. carry changes only on ADD and SUB.
- Memory writes occur only in T4 (or via the load port). A read of the just-written word in the next instruction sees the new value.
- Arithmetic is unsigned modulo 2^DATA_W. All address arithmetic is modulo 2^ADDR_W.

Optional Feature:
ACC_CPU_ISZ_EN
- Defined: opcode 011 becomes ISZ. In T4, M[AR]<=M[AR]+1; if the result is 0, pc<=pc+1 (skip next instruction, with wrap).
- Undefined: opcode 011 is DBL as above. No other behaviour differs.

Test Plan:
1. DATA_W=8, ADDR_W=4, program loaded under rst: M0=48, M1=09, M2=5A, M3=F0, M8=30, M9=E0. Release rst -> ac=30 after the 1st instr_done; ac=10 with carry=1 after the 2nd; M[A]=10 after the 3rd; halted=1 at the 19th edge after release; pc=4; exactly 3 instr_done pulses.
2. SUB borrow: M0=48, M1=19, M8=05, M9=07 -> ac=FE, carry=0, zero=0.
3. Indirect LDA: M0=C5, M5=0B, MB=77 -> ac=77 after one instruction (5 cycles).
4. JMP wrap: RESET_PC=F, MF=72, M2=F0 -> pc=2 after the JMP executes; halted follows 4 cycles later; pc=3.
5. Reset during the T4 cycle of STA (M0=5A, ac preloaded via a prior LDA) -> M[A] unchanged, ac=0, pc=RESET_PC, zero=1, instr_done=0 on that edge.
6. M0=36, M6=FF: with ACC_CPU_ISZ_EN -> M6=00, pc=2 after the instruction. Without the macro -> M6=FE, pc=1.

Source files
------------

// File: rtl/acc_cpu_param.sv
// Parametrised five-phase accumulator CPU with unified memory, load port, carry/zero flags and JMP/HLT.
// Build option: define ACC_CPU_ISZ_EN to turn opcode 011 from DBL into ISZ (increment, skip on zero).
module acc_cpu_param #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 4,
  parameter int    RESET_PC  = 0,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] ac,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              zero,
  output logic              halted,
  output logic              instr_done
);

  // Instruction word: {I, opcode[2:0], address[ADDR_W-1:0]}; DATA_W must be at least ADDR_W+4.
  localparam int IW    = ADDR_W + 4;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] ONE_D  = DATA_W'(1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_DBL = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_CMM = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ar;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W-1:0] sub_dif;
  logic [DATA_W-1:0] xor_res;
  logic [DATA_W-1:0] inc_res;
  logic              ir_ind;
  logic [2:0]        ir_op;
  logic [ADDR_W-1:0] ir_addr;

  // Asynchronous read: a word written in T4 is visible to the very next fetch.
  assign mem_rd  = mem[ar];
  assign add_sum = {1'b0, ac} + {1'b0, mem_rd};
  assign sub_dif = ac - mem_rd;
  assign xor_res = ac ^ mem_rd;
  assign inc_res = mem_rd + ONE_D;

  assign ir_ind  = ir[IW-1];
  assign ir_op   = ir[IW-2:ADDR_W];
  assign ir_addr = ir[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ac         <= '0;
      pc         <= PC_RST;
      carry      <= 1'b0;
      zero       <= 1'b1;
      halted     <= 1'b0;
      instr_done <= 1'b0;
      state      <= S_T0;
      ar         <= '0;
      ir         <= '0;
      if (ld_en) mem[ld_addr] <= ld_data;
    end else begin
      instr_done <= 1'b0;
      case (state)
        S_T0: begin
          ar    <= pc;
          state <= S_T1;
        end
        S_T1: begin
          ir    <= mem_rd[IW-1:0];
          pc    <= pc + ONE_A;
          state <= S_T2;
        end
        S_T2: begin
          ar    <= ir_addr;
          state <= S_T3;
        end
        S_T3: begin
          // Opcode 111 with I set is HLT; with I clear it is a direct JMP.
          if (ir_ind && ir_op == OP_JMP) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            if (ir_ind) ar <= mem_rd[ADDR_W-1:0];
            state <= S_T4;
          end
        end
        S_T4: begin
          instr_done <= 1'b1;
          state      <= S_T0;
          case (ir_op)
            OP_ADD: begin
              carry <= add_sum[DATA_W];
              ac    <= add_sum[DATA_W-1:0];
              zero  <= (add_sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              carry <= (ac >= mem_rd);
              ac    <= sub_dif;
              zero  <= (sub_dif == '0);
            end
            OP_XOR: begin
              ac   <= xor_res;
              zero <= (xor_res == '0);
            end
            OP_DBL: begin
`ifdef ACC_CPU_ISZ_EN
              mem[ar] <= inc_res;
              if (inc_res == '0) pc <= pc + ONE_A;
`else
              mem[ar] <= mem_rd + mem_rd;
`endif
            end
            OP_LDA: begin
              ac   <= mem_rd;
              zero <= (mem_rd == '0);
            end
            OP_STA: mem[ar] <= ac;
            OP_CMM: mem[ar] <= ~mem_rd;
            OP_JMP: pc <= ar;
            default: ;
          endcase
        end
        S_HALT: state <= S_HALT;
        default: state <= S_T0;
      endcase
    end
  end

`ifndef ACC_CPU_ISZ_EN
  logic unused_inc;
  assign unused_inc = ^inc_res;
`endif

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param: programs are loaded under reset, outputs are checked
// one time unit after rising edges against hand-computed values.
module tb_acc_cpu_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_f = 1'b1;
    logic       ld_en = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    logic [7:0] ac, ac_f;
    logic [3:0] pc, pc_f;
    logic       carry, carry_f, zero, zero_f, halted, halted_f, instr_done, instr_done_f;

    int checks = 0;
    int failures = 0;
    int n_done;

    always #5 clk = ~clk;

    acc_cpu_param u_dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ac(ac), .pc(pc), .carry(carry), .zero(zero), .halted(halted), .instr_done(instr_done)
    );

    acc_cpu_param #(.RESET_PC(15)) u_dut_f (
        .clk(clk), .rst(rst_f), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ac(ac_f), .pc(pc_f), .carry(carry_f), .zero(zero_f), .halted(halted_f),
        .instr_done(instr_done_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs until the next instr_done pulse (bounded) and checks the cycle count.
    task automatic run_instr(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!instr_done && n < 20);
        check({tag, "_cycles"}, n, exp_cycles);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ac", ac, 8'h00);
        check("rst_pc", pc, 4'h0);
        check("rst_carry", carry, 1'b0);
        check("rst_zero", zero, 1'b1);
        check("rst_halted", halted, 1'b0);
        check("rst_done", instr_done, 1'b0);
        check("rst_pc_f", pc_f, 4'hF);

        // Test 1: LDA 8, ADD 9, STA A, HLT
        load(4'h0, 8'h48);
        load(4'h1, 8'h09);
        load(4'h2, 8'h5A);
        load(4'h3, 8'hF0);
        load(4'h8, 8'h30);
        load(4'h9, 8'hE0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (instr_done) n_done++;
            if (i == 5) check("t1_lda_ac", ac, 8'h30);
            if (i == 10) begin
                check("t1_add_ac", ac, 8'h10);
                check("t1_add_carry", carry, 1'b1);
                check("t1_add_zero", zero, 1'b0);
            end
            if (i == 15) check("t1_sta_mem", u_dut.mem[10], 8'h10);
            if (i == 18) check("t1_not_halted_18", halted, 1'b0);
        end
        check("t1_halted_19", halted, 1'b1);
        check("t1_pc", pc, 4'h4);
        check("t1_done_count", n_done, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (instr_done) n_done++;
        end
        check("t1_frozen_pc", pc, 4'h4);
        check("t1_frozen_halted", halted, 1'b1);
        check("t1_frozen_count", n_done, 3);
        check("t1_frozen_ac", ac, 8'h10);

        // Test 2: SUB with borrow
        rst = 1'b1;
        tick();
        load(4'h0, 8'h48);
        load(4'h1, 8'h19);
        load(4'h2, 8'hF0);
        load(4'h8, 8'h05);
        load(4'h9, 8'h07);
        rst = 1'b0;
        run_instr("t2_lda", 5);
        check("t2_lda_ac", ac, 8'h05);
        run_instr("t2_sub", 5);
        check("t2_sub_ac", ac, 8'hFE);
        check("t2_sub_carry", carry, 1'b0);
        check("t2_sub_zero", zero, 1'b0);

        // Test 3: indirect LDA
        rst = 1'b1;
        tick();
        load(4'h0, 8'hC5);
        load(4'h5, 8'h0B);
        load(4'hB, 8'h77);
        rst = 1'b0;
        run_instr("t3_lda_ind", 5);
        check("t3_ac", ac, 8'h77);
        check("t3_pc", pc, 4'h1);

        // Test 4: JMP with pc wrap from RESET_PC=F
        rst = 1'b1;
        tick();
        load(4'hF, 8'h72);
        load(4'h2, 8'hF0);
        rst_f = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t4_jmp_pc", pc_f, 4'h2);
        check("t4_jmp_done", instr_done_f, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("t4_not_halted", halted_f, 1'b0);
        tick();
        check("t4_halted", halted_f, 1'b1);
        check("t4_halt_pc", pc_f, 4'h3);
        rst_f = 1'b1;

        // Test 5: reset during T4 of STA abandons the store
        load(4'h0, 8'h48);
        load(4'h1, 8'h5A);
        load(4'h8, 8'h30);
        load(4'hA, 8'h11);
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 5) check("t5_preload_ac", ac, 8'h30);
        end
        rst = 1'b1;
        tick();
        check("t5_mem_kept", u_dut.mem[10], 8'h11);
        check("t5_ac", ac, 8'h00);
        check("t5_pc", pc, 4'h0);
        check("t5_zero", zero, 1'b1);
        check("t5_done", instr_done, 1'b0);

        // Test 6: opcode 011 (DBL, or ISZ when enabled)
        load(4'h0, 8'h36);
        load(4'h6, 8'hFF);
        load(4'h1, 8'hF0);
        rst = 1'b0;
        run_instr("t6_op3", 5);
`ifdef ACC_CPU_ISZ_EN
        check("t6_isz_mem", u_dut.mem[6], 8'h00);
        check("t6_isz_pc", pc, 4'h2);
`else
        check("t6_dbl_mem", u_dut.mem[6], 8'hFE);
        check("t6_dbl_pc", pc, 4'h1);
`endif

        // Test 7: XOR to zero keeps carry, CMM complements memory
        rst = 1'b1;
        tick();
        load(4'h0, 8'h48);
        load(4'h1, 8'h28);
        load(4'h2, 8'h69);
        load(4'h8, 8'h0F);
        load(4'h9, 8'h3C);
        rst = 1'b0;
        run_instr("t7_lda", 5);
        check("t7_lda_zero", zero, 1'b0);
        run_instr("t7_xor", 5);
        check("t7_xor_ac", ac, 8'h00);
        check("t7_xor_zero", zero, 1'b1);
        check("t7_xor_carry", carry, 1'b0);
        run_instr("t7_cmm", 5);
        check("t7_cmm_mem", u_dut.mem[9], 8'hC3);
        check("t7_cmm_ac", ac, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
